therm2bin_decoder: RTL and testbench

- Receive end of the thermometer-code path. Samples an asynchronous thermometer bus from pins, synchronises it and filters it for stability, then validates it (optional bubble correction) and converts it to a binary count.
- Each newly settled code is presented once on a valid/ready output.
- Pairs with the binary-to-thermometer encoder on the TT tile; keeps sticky error and overrun status for debug readout.

---
 rtl/therm2bin_if.sv | 25 ++
 rtl/therm2bin_decoder.sv | 148 ++++++++++++++
 tb/tb_therm2bin_decoder.sv | 251 +++++++++++++++++++++++++
 3 files changed

// File: rtl/therm2bin_if.sv
// Bundles the decoder's pin-side, stream-output and status signals.
// The decoder sits on the slave modport; a driver or consumer sits on master.
interface therm2bin_if #(
  parameter int WIDTH = 15
) ();
  localparam int BW = $clog2(WIDTH + 1);

  logic [WIDTH-1:0] therm_in;
  logic             out_ready;
  logic             out_valid;
  logic [BW-1:0]    out_bin;
  logic             clear_err;
  logic [7:0]       err_cnt;
  logic             ovr;

  modport master (
    output therm_in, out_ready, clear_err,
    input  out_valid, out_bin, err_cnt, ovr
  );

  modport slave (
    input  therm_in, out_ready, clear_err,
    output out_valid, out_bin, err_cnt, ovr
  );
endinterface

// File: rtl/therm2bin_decoder.sv
// Thermometer-to-binary receive decoder.
// The asynchronous thermometer bus is synchronised, held until it has been
// identical for STABLE_CYCLES samples, then validated and converted into a
// count of set bits. Each new settled code is offered once on a valid/ready
// output. Illegal codes bump a saturating error counter, and a sample that
// is overwritten before delivery sets a sticky overrun flag.
// Optional build macro THERM2BIN_BUBBLE_CORRECT_EN adds a 3-input majority
// corrector that repairs single-bit bubbles before validation.
module therm2bin_decoder #(
  parameter int WIDTH         = 15,
  parameter int STABLE_CYCLES = 16
) (
  input logic        clk,
  input logic        rst,
  therm2bin_if.slave bus
);
  localparam int BW = $clog2(WIDTH + 1);
  localparam int SW = $clog2(STABLE_CYCLES);
  localparam logic [SW-1:0] STAB_MAX = SW'(STABLE_CYCLES - 1);

  localparam logic [0:0] ST_EMPTY = 1'b0;
  localparam logic [0:0] ST_FULL  = 1'b1;

  logic [WIDTH-1:0] s1;
  logic [WIDTH-1:0] s2;
  logic [WIDTH-1:0] cand;
  logic [WIDTH-1:0] last_code;
  logic [WIDTH-1:0] code_chk;
  logic [WIDTH-1:0] code_p1;
  logic [SW-1:0]    stab_cnt;
  logic [0:0]       state;
  logic [BW-1:0]    out_bin_q;
  logic [BW-1:0]    bin;
  logic [7:0]       err_q;
  logic             ovr_q;
  logic             accept;
  logic             legal;
  logic             legal_acc;
  logic             illegal_acc;
  logic             overwrite;

  // Two-flop synchroniser on every pin of the asynchronous bus
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1 <= '0;
      s2 <= '0;
    end else begin
      s1 <= bus.therm_in;
      s2 <= s1;
    end
  end

  // Stability filter: restart on any change, otherwise count up to the limit
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cand     <= '0;
      stab_cnt <= '0;
    end else if (s2 != cand) begin
      cand     <= s2;
      stab_cnt <= '0;
    end else if (stab_cnt != STAB_MAX) begin
      stab_cnt <= stab_cnt + 1'b1;
    end
  end

  // A settled code is processed only once, until a different code settles
  assign accept = (stab_cnt == STAB_MAX) && (cand != last_code);

  // Remember the last processed code so a held code does not re-trigger
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      last_code <= '0;
    end else if (accept) begin
      last_code <= cand;
    end
  end

`ifdef THERM2BIN_BUBBLE_CORRECT_EN
  logic [WIDTH+1:0] padded;
  assign padded = {1'b0, cand, 1'b1};

  // Majority of each bit and its neighbours; below bit0 reads 1, above the top reads 0
  always_comb begin
    code_chk = '0;
    for (int i = 0; i < WIDTH; i++) begin
      code_chk[i] = (padded[i] & padded[i+1]) |
                    (padded[i+1] & padded[i+2]) |
                    (padded[i] & padded[i+2]);
    end
  end
`else
  assign code_chk = cand;
`endif

  // A thermometer code plus one clears every set bit, so the AND is zero
  assign code_p1 = code_chk + 1'b1;
  assign legal   = ((code_chk & code_p1) == '0);

  // Binary value is the position of the highest set bit plus one
  always_comb begin
    bin = '0;
    for (int i = 0; i < WIDTH; i++) begin
      if (code_chk[i]) begin
        bin = BW'(i + 1);
      end
    end
  end

  assign legal_acc   = accept && legal;
  assign illegal_acc = accept && !legal;
  assign overwrite   = legal_acc && (state == ST_FULL) && !bus.out_ready;

  // Output holding register: load on a legal code, drain on handshake
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= ST_EMPTY;
      out_bin_q <= '0;
    end else if (legal_acc) begin
      state     <= ST_FULL;
      out_bin_q <= bin;
    end else if ((state == ST_FULL) && bus.out_ready) begin
      state     <= ST_EMPTY;
    end
  end

  // Sticky status; a same-cycle event wins over the clear
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      err_q <= '0;
      ovr_q <= 1'b0;
    end else if (bus.clear_err) begin
      err_q <= illegal_acc ? 8'd1 : 8'd0;
      ovr_q <= overwrite;
    end else begin
      if (illegal_acc && (err_q != 8'd255)) begin
        err_q <= err_q + 8'd1;
      end
      if (overwrite) begin
        ovr_q <= 1'b1;
      end
    end
  end

  assign bus.out_valid = (state == ST_FULL);
  assign bus.out_bin   = out_bin_q;
  assign bus.err_cnt   = err_q;
  assign bus.ovr       = ovr_q;
endmodule

// File: tb/tb_therm2bin_decoder.sv
// Self-checking bench for therm2bin_decoder.
// A reference model built from sample-history windows predicts every cycle's
// outputs; directed steps cover latency, glitches, overrun, illegal codes,
// reset and error saturation, followed by a randomised phase.
// Honours THERM2BIN_BUBBLE_CORRECT_EN when choosing expected values.
module tb_therm2bin_decoder;
  localparam int W  = 15;
  localparam int SC = 16;

  logic clk;
  logic rst;

  therm2bin_if #(.WIDTH(W)) bus ();

  therm2bin_decoder #(.WIDTH(W), .STABLE_CYCLES(SC)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int testCount = 0;
  int failCount = 0;

  // Reference model state
  logic [W-1:0] samples[$];
  logic [W-1:0] inHist[$];
  logic [W-1:0] lastAcc;
  bit           mValid;
  int           mBin;
  int           mErr;
  bit           mOvr;

  function automatic logic [W-1:0] correctCode(input logic [W-1:0] c);
`ifdef THERM2BIN_BUBBLE_CORRECT_EN
    logic [W-1:0] r;
    int lo, hi;
    for (int i = 0; i < W; i++) begin
      lo = (i == 0) ? 1 : int'(c[i-1]);
      hi = (i == W-1) ? 0 : int'(c[i+1]);
      r[i] = ((lo + int'(c[i]) + hi) >= 2);
    end
    return r;
`else
    return c;
`endif
  endfunction

  task automatic checkEq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    testCount++;
    assert (got === exp) else begin
      failCount++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic checkOutput(input string tag);
    checkEq({tag, ".valid"}, 32'(bus.out_valid), 32'(mValid));
    checkEq({tag, ".bin"},   32'(bus.out_bin),   32'(mBin));
    checkEq({tag, ".err"},   32'(bus.err_cnt),   32'(mErr));
    checkEq({tag, ".ovr"},   32'(bus.ovr),       32'(mOvr));
  endtask

  task automatic applyStimulus(input logic [W-1:0] code, input logic rdy, input logic clr);
    bus.therm_in  = code;
    bus.out_ready = rdy;
    bus.clear_err = clr;
  endtask

  task automatic modelClear();
    samples.delete();
    inHist.delete();
    samples.push_back('0);
    lastAcc = '0;
    mValid  = 1'b0;
    mBin    = 0;
    mErr    = 0;
    mOvr    = 1'b0;
  endtask

  // One clock edge: advance the model using pre-edge inputs, then compare
  task automatic stepCycle(input string tag);
    int n;
    bit accept, allEq, inc, ovw;
    logic [W-1:0] cand, code, newSample;
    int pc;
    @(posedge clk);
    n = samples.size();
    accept = 1'b0;
    inc = 1'b0;
    ovw = 1'b0;
    cand = samples[n-1];
    if (n - SC >= 0) begin
      allEq = 1'b1;
      for (int j = n - SC; j < n; j++)
        if (samples[j] != cand) allEq = 1'b0;
      accept = allEq && (cand != lastAcc);
    end
    newSample = (n <= 2) ? '0 : inHist[n-3];
    if (accept) begin
      lastAcc = cand;
      code = correctCode(cand);
      pc = $countones(code);
      if (int'(code) == ((1 << pc) - 1)) begin
        ovw = mValid && !bus.out_ready;
        mValid = 1'b1;
        mBin = pc;
      end else begin
        inc = 1'b1;
      end
    end else if (mValid && bus.out_ready) begin
      mValid = 1'b0;
    end
    if (bus.clear_err) begin
      mErr = inc ? 1 : 0;
      mOvr = ovw;
    end else begin
      if (inc && mErr < 255) mErr++;
      if (ovw) mOvr = 1'b1;
    end
    samples.push_back(newSample);
    inHist.push_back(bus.therm_in);
    #1;
    checkOutput(tag);
  endtask

  // Asynchronous reset assertion, checked before any clock edge, then release
  task automatic doReset();
    rst = 1'b1;
    #1;
    modelClear();
    checkOutput("reset_async");
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    int first, vcount;
    logic [W-1:0] code;
    int hold;

    rst = 1'b1;
    applyStimulus('0, 1'b1, 1'b0);
    doReset();

    // Latency and single delivery of a held code
    applyStimulus(15'h007F, 1'b1, 1'b0);
    first = 0;
    vcount = 0;
    for (int i = 1; i <= 60; i++) begin
      stepCycle("hold7f");
      if (bus.out_valid) begin
        vcount++;
        if (first == 0) first = i;
      end
      if (i == first && first != 0) checkEq("bin7", 32'(bus.out_bin), 32'd7);
    end
    checkEq("latency7f", 32'(first), 32'd19);
    checkEq("once7f", 32'(vcount), 32'd1);

    // Short glitch to 0xFF must not produce an event
    applyStimulus(15'h00FF, 1'b1, 1'b0);
    vcount = 0;
    for (int i = 0; i < 10; i++) begin
      stepCycle("glitch");
      if (bus.out_valid) vcount++;
    end
    applyStimulus(15'h007F, 1'b1, 1'b0);
    for (int i = 0; i < 40; i++) begin
      stepCycle("glitch_back");
      if (bus.out_valid) vcount++;
    end
    checkEq("glitch_novalid", 32'(vcount), 32'd0);
    checkEq("glitch_err", 32'(bus.err_cnt), 32'd0);
    checkEq("glitch_ovr", 32'(bus.ovr), 32'd0);

    // Overwrite while the consumer stalls
    applyStimulus(15'h0003, 1'b0, 1'b0);
    for (int i = 0; i < 25; i++) stepCycle("ovr_a");
    applyStimulus(15'h7FFF, 1'b0, 1'b0);
    for (int i = 0; i < 25; i++) stepCycle("ovr_b");
    checkEq("ovr_valid", 32'(bus.out_valid), 32'd1);
    checkEq("ovr_bin", 32'(bus.out_bin), 32'd15);
    checkEq("ovr_flag", 32'(bus.ovr), 32'd1);
    applyStimulus(15'h7FFF, 1'b1, 1'b0);
    stepCycle("drain");
    checkEq("drain_valid", 32'(bus.out_valid), 32'd0);

    // Bubbled code 0x0017
    applyStimulus(15'h0017, 1'b1, 1'b0);
    for (int i = 0; i < 120; i++) stepCycle("bubble");
`ifdef THERM2BIN_BUBBLE_CORRECT_EN
    checkEq("bubble_err", 32'(bus.err_cnt), 32'd0);
    checkEq("bubble_bin", 32'(bus.out_bin), 32'd4);
`else
    checkEq("bubble_err", 32'(bus.err_cnt), 32'd1);
    checkEq("bubble_bin", 32'(bus.out_bin), 32'd15);
`endif

    // Reset while a sample is pending, then full latency again
    applyStimulus(15'h0003, 1'b0, 1'b0);
    for (int i = 0; i < 25; i++) stepCycle("pend");
    checkEq("pend_valid", 32'(bus.out_valid), 32'd1);
    applyStimulus(15'h007F, 1'b1, 1'b0);
    doReset();
    checkEq("rst_valid", 32'(bus.out_valid), 32'd0);
    checkEq("rst_err", 32'(bus.err_cnt), 32'd0);
    first = 0;
    for (int i = 1; i <= 30; i++) begin
      stepCycle("relatency");
      if (bus.out_valid && first == 0) begin
        first = i;
        checkEq("rebin7", 32'(bus.out_bin), 32'd7);
      end
    end
    checkEq("relatency19", 32'(first), 32'd19);

    // Error counter saturation and clear
    for (int k = 0; k < 300; k++) begin
      applyStimulus((k % 2 == 0) ? 15'h0005 : 15'h0009, 1'b1, 1'b0);
      for (int i = 0; i < 20; i++) stepCycle("sat");
    end
`ifndef THERM2BIN_BUBBLE_CORRECT_EN
    checkEq("sat255", 32'(bus.err_cnt), 32'd255);
`endif
    applyStimulus(15'h0009, 1'b1, 1'b1);
    stepCycle("clear");
    checkEq("clear0", 32'(bus.err_cnt), 32'd0);
    applyStimulus(15'h0009, 1'b1, 1'b0);
    stepCycle("after_clear");

    // Randomised segments of legal and arbitrary codes
    for (int s = 0; s < 150; s++) begin
      if ($urandom_range(0, 3) != 0)
        code = W'((1 << $urandom_range(0, W)) - 1);
      else
        code = W'($urandom);
      hold = $urandom_range(1, 40);
      for (int i = 0; i < hold; i++) begin
        applyStimulus(code, ($urandom_range(0, 9) < 7), ($urandom_range(0, 99) < 3));
        stepCycle("random");
      end
    end

    $display("[TB] %0d tests run, %0d failed", testCount, failCount);
    $finish;
  end
endmodule
